// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the ID/EX stage
package pipe_pkg;

   localparam int XLEN = 64;

   localparam logic [1:0] ALUOP_LDST   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - combinational load-use hazard detection with flush override
module hazard_detect_unit (
   input  logic       EX_valid,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rd,
   input  logic [4:0] ID_rs1,
   input  logic [4:0] ID_rs2,
   input  logic       ID_valid,
   input  logic       flush,
   output logic       stall,
   output logic       PCWrite,
   output logic       IF_ID_Write
);

   logic hazard;

   // A load writing x0 never creates a dependency.
   assign hazard = EX_valid & EX_MemRead & (EX_rd != 5'd0)
                 & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2)) & ID_valid;

   assign stall       = hazard & ~flush;
   assign PCWrite     = ~stall;
   assign IF_ID_Write = ~stall;

endmodule

// File: rtl/id_ex_pipeline.sv
// rtl/id_ex_pipeline.sv - ID/EX register with bubble insertion, WB bypass and event counters
module id_ex_pipeline
   import pipe_pkg::*;
#(
   parameter int XLEN  = pipe_pkg::XLEN,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  ID_PC,
   input  logic [XLEN-1:0]  ID_readData1,
   input  logic [XLEN-1:0]  ID_readData2,
   input  logic [XLEN-1:0]  ID_imm,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic [4:0]       ID_rd,
   input  logic [2:0]       ID_funct3,
   input  logic [6:0]       ID_funct7,
   input  logic [1:0]       ID_ALUOp,
   input  logic             ID_ALUSrc,
   input  logic             ID_Branch,
   input  logic             ID_MemRead,
   input  logic             ID_MemWrite,
   input  logic             ID_MemtoReg,
   input  logic             ID_RegWrite,
   input  logic             ID_valid,
   input  logic             flush,
   input  logic             WB_RegWrite,
   input  logic [4:0]       WB_rd,
   input  logic [XLEN-1:0]  WB_data,
   output logic [XLEN-1:0]  EX_PC,
   output logic [XLEN-1:0]  EX_readData1,
   output logic [XLEN-1:0]  EX_readData2,
   output logic [XLEN-1:0]  EX_imm,
   output logic [4:0]       EX_rs1,
   output logic [4:0]       EX_rs2,
   output logic [4:0]       EX_rd,
   output logic [2:0]       EX_funct3,
   output logic [6:0]       EX_funct7,
   output logic [1:0]       EX_ALUOp,
   output logic             EX_ALUSrc,
   output logic             EX_Branch,
   output logic             EX_MemRead,
   output logic             EX_MemWrite,
   output logic             EX_MemtoReg,
   output logic             EX_RegWrite,
   output logic             EX_valid,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   logic [XLEN-1:0]  pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [2:0]       f3_q, f3_d;
   logic [6:0]       f7_q, f7_d;
   id_ex_ctrl_t      ctrl_q, ctrl_d, id_ctrl;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             bubble;

   hazard_detect_unit u_hazard (
      .EX_valid    (valid_q),
      .EX_MemRead  (ctrl_q.mem_read),
      .EX_rd       (rd_q),
      .ID_rs1      (ID_rs1),
      .ID_rs2      (ID_rs2),
      .ID_valid    (ID_valid),
      .flush       (flush),
      .stall       (stall),
      .PCWrite     (PCWrite),
      .IF_ID_Write (IF_ID_Write)
   );

   assign id_ctrl = '{alu_op:     ID_ALUOp,
                      alu_src:    ID_ALUSrc,
                      branch:     ID_Branch,
                      mem_read:   ID_MemRead,
                      mem_write:  ID_MemWrite,
                      mem_to_reg: ID_MemtoReg,
                      reg_write:  ID_RegWrite};

   assign bubble = flush | stall;

   always_comb begin
      pc_d        = ID_PC;
      imm_d       = ID_imm;
      rs1_d       = ID_rs1;
      rs2_d       = ID_rs2;
      rd_d        = ID_rd;
      f3_d        = ID_funct3;
      f7_d        = ID_funct7;
      // Write-back lands in the regfile too late for this read; forward it here.
      rd1_d       = (WB_RegWrite && (WB_rd != 5'd0) && (WB_rd == ID_rs1)) ? WB_data : ID_readData1;
      rd2_d       = (WB_RegWrite && (WB_rd != 5'd0) && (WB_rd == ID_rs2)) ? WB_data : ID_readData2;
      ctrl_d      = bubble ? CTRL_BUBBLE : id_ctrl;
      valid_d     = ID_valid & ~bubble;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         f3_q        <= '0;
         f7_q        <= '0;
         ctrl_q      <= CTRL_BUBBLE;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         f3_q        <= f3_d;
         f7_q        <= f7_d;
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign EX_PC        = pc_q;
   assign EX_readData1 = rd1_q;
   assign EX_readData2 = rd2_q;
   assign EX_imm       = imm_q;
   assign EX_rs1       = rs1_q;
   assign EX_rs2       = rs2_q;
   assign EX_rd        = rd_q;
   assign EX_funct3    = f3_q;
   assign EX_funct7    = f7_q;
   assign EX_ALUOp     = ctrl_q.alu_op;
   assign EX_ALUSrc    = ctrl_q.alu_src;
   assign EX_Branch    = ctrl_q.branch;
   assign EX_MemRead   = ctrl_q.mem_read;
   assign EX_MemWrite  = ctrl_q.mem_write;
   assign EX_MemtoReg  = ctrl_q.mem_to_reg;
   assign EX_RegWrite  = ctrl_q.reg_write;
   assign EX_valid     = valid_q;
   assign stall_count  = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
// tb/tb_id_ex_pipeline.sv - scoreboard bench for id_ex_pipeline against a behavioural model
module tb_id_ex_pipeline;

   localparam int CW = 4;

   typedef struct packed {
      logic [63:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [1:0]  aluop;
      logic        alusrc, branch, memread, memwrite, memtoreg, regwrite, valid;
   } ex_t;

   typedef struct {
      logic          stall;
      ex_t           nxt;
      logic [CW-1:0] sc, fc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   ex_t  id_in;
   logic flush, wb_we;
   logic [4:0] wb_rd;
   logic [63:0] wb_data;

   logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_f3;
   logic [6:0]  ex_f7;
   logic [1:0]  ex_aluop;
   logic ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_valid;
   logic pcwrite, ifid_write, stall;
   logic [CW-1:0] stall_count, flush_count;

   exp_t q[$];
   ex_t  m_ex;
   int   m_sc, m_fc;
   int   n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   id_ex_pipeline #(.XLEN(64), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .ID_PC(id_in.pc), .ID_readData1(id_in.rd1), .ID_readData2(id_in.rd2), .ID_imm(id_in.imm),
      .ID_rs1(id_in.rs1), .ID_rs2(id_in.rs2), .ID_rd(id_in.rd),
      .ID_funct3(id_in.f3), .ID_funct7(id_in.f7), .ID_ALUOp(id_in.aluop),
      .ID_ALUSrc(id_in.alusrc), .ID_Branch(id_in.branch), .ID_MemRead(id_in.memread),
      .ID_MemWrite(id_in.memwrite), .ID_MemtoReg(id_in.memtoreg), .ID_RegWrite(id_in.regwrite),
      .ID_valid(id_in.valid), .flush(flush),
      .WB_RegWrite(wb_we), .WB_rd(wb_rd), .WB_data(wb_data),
      .EX_PC(ex_pc), .EX_readData1(ex_rd1), .EX_readData2(ex_rd2), .EX_imm(ex_imm),
      .EX_rs1(ex_rs1), .EX_rs2(ex_rs2), .EX_rd(ex_rd),
      .EX_funct3(ex_f3), .EX_funct7(ex_f7), .EX_ALUOp(ex_aluop),
      .EX_ALUSrc(ex_alusrc), .EX_Branch(ex_branch), .EX_MemRead(ex_memread),
      .EX_MemWrite(ex_memwrite), .EX_MemtoReg(ex_memtoreg), .EX_RegWrite(ex_regwrite),
      .EX_valid(ex_valid),
      .PCWrite(pcwrite), .IF_ID_Write(ifid_write), .stall(stall),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic ex_t rand_data();
      ex_t t;
      t.pc  = {$urandom, $urandom};
      t.rd1 = {$urandom, $urandom};
      t.rd2 = {$urandom, $urandom};
      t.imm = {$urandom, $urandom};
      t.f3  = 3'($urandom);
      t.f7  = 7'($urandom);
      return t;
   endfunction

   function automatic ex_t mk(int rs1, int rs2, int rd, bit mr, bit rw, logic [1:0] op);
      ex_t t = rand_data();
      t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
      t.aluop = op; t.alusrc = mr; t.branch = 1'b0; t.memread = mr;
      t.memwrite = 1'b0; t.memtoreg = mr; t.regwrite = rw; t.valid = 1'b1;
      return t;
   endfunction

   function automatic ex_t rand_instr();
      ex_t t = rand_data();
      t.rs1 = 5'($urandom_range(0, 7));
      t.rs2 = 5'($urandom_range(0, 7));
      t.rd  = 5'($urandom_range(0, 7));
      t.aluop = 2'($urandom);
      {t.alusrc, t.branch, t.memwrite, t.memtoreg, t.regwrite} = 5'($urandom);
      t.memread = ($urandom_range(0, 2) == 0);
      t.valid   = ($urandom_range(0, 7) != 0);
      return t;
   endfunction

   // One cycle: apply inputs, predict this cycle's stall and the EX contents after the edge.
   task automatic drive(input ex_t in, input logic fl, input logic we, input logic [4:0] wrd,
                        input logic [63:0] wd, input logic rst, output logic st);
      ex_t  nx;
      exp_t e;
      logic uses_load;
      id_in = in; flush = fl; wb_we = we; wb_rd = wrd; wb_data = wd; reset = rst;
      uses_load = m_ex.valid && m_ex.memread && (m_ex.rd != 0) && in.valid
                  && (m_ex.rd == in.rs1 || m_ex.rd == in.rs2);
      st = uses_load && !fl;
      nx = in;
      if (we && wrd != 0 && wrd == in.rs1) nx.rd1 = wd;
      if (we && wrd != 0 && wrd == in.rs2) nx.rd2 = wd;
      if (fl || st) begin
         nx.valid = 0; nx.regwrite = 0; nx.memread = 0; nx.memwrite = 0;
         nx.branch = 0; nx.memtoreg = 0; nx.alusrc = 0; nx.aluop = 2'b00;
      end
      if (rst) begin
         nx = '0; m_sc = 0; m_fc = 0;
      end else begin
         if (st && m_sc < (1 << CW) - 1) m_sc++;
         if (fl && m_fc < (1 << CW) - 1) m_fc++;
      end
      e.stall = st; e.nxt = nx; e.sc = CW'(m_sc); e.fc = CW'(m_fc);
      q.push_back(e);
      m_ex = nx;
      @(posedge clk); #1;
   endtask

   task automatic issue(input ex_t in, input logic fl);
      logic st;
      drive(in, fl, 1'b0, 5'd0, 64'd0, 1'b0, st);
      while (st) drive(in, fl, 1'b0, 5'd0, 64'd0, 1'b0, st);
   endtask

   initial begin : monitor
      exp_t prev, r;
      ex_t  act;
      bit   has_prev = 0;
      forever begin
         @(negedge clk);
         if (has_prev) begin
            act = '{ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_f3, ex_f7, ex_aluop,
                    ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_valid};
            chk("ex_regs", 300'(act), 300'(prev.nxt));
            chk("ex_valid", 300'(ex_valid), 300'(prev.nxt.valid));
            chk("stall_count", 300'(stall_count), 300'(prev.sc));
            chk("flush_count", 300'(flush_count), 300'(prev.fc));
         end
         if (q.size() > 0) begin
            r = q.pop_front();
            chk("stall", 300'(stall), 300'(r.stall));
            chk("PCWrite", 300'(pcwrite), 300'(!r.stall));
            chk("IF_ID_Write", 300'(ifid_write), 300'(!r.stall));
            prev = r;
            has_prev = 1;
         end else begin
            has_prev = 0;
         end
      end
   end

   initial begin : stimulus
      logic st;
      ex_t  cur;
      m_ex = '0; m_sc = 0; m_fc = 0;
      id_in = rand_instr(); flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0; reset = 1;
      @(posedge clk); #1;
      drive(rand_instr(), 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, st);

      issue(mk(1, 2, 5, 0, 1, 2'b10), 1'b0);
      issue(mk(1, 0, 6, 1, 1, 2'b00), 1'b0);
      issue(mk(6, 3, 7, 0, 1, 2'b10), 1'b0);
      drive(mk(1, 0, 6, 1, 1, 2'b00), 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, st);
      drive(mk(6, 3, 7, 0, 1, 2'b10), 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, st);
      cur = mk(1, 4, 8, 0, 1, 2'b10); cur.rd2 = 64'd0;
      drive(cur, 1'b0, 1'b1, 5'd4, 64'h1234, 1'b0, st);
      cur = mk(0, 4, 8, 0, 1, 2'b10); cur.rd1 = 64'd0; cur.rd2 = 64'd0;
      drive(cur, 1'b0, 1'b1, 5'd0, 64'h1234, 1'b0, st);
      issue(mk(1, 0, 0, 1, 1, 2'b00), 1'b0);
      issue(mk(0, 0, 9, 0, 1, 2'b10), 1'b0);
      issue(mk(2, 0, 6, 1, 1, 2'b00), 1'b0);
      issue(mk(6, 6, 9, 0, 1, 2'b10), 1'b0);
      drive(mk(2, 0, 6, 1, 1, 2'b00), 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, st);
      drive(mk(6, 1, 9, 0, 1, 2'b10), 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, st);
      drive(mk(6, 1, 9, 0, 1, 2'b10), 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, st);

      // Enough load-use pairs and flushes to drive both counters into saturation.
      for (int i = 0; i < 18; i++) begin
         issue(mk(1, 2, 3, 1, 1, 2'b00), 1'b0);
         issue(mk(3, 1, 4, 0, 1, 2'b10), 1'b0);
         issue(mk(1, 1, 1, 0, 0, 2'b01), 1'b1);
      end

      st = 0;
      cur = rand_instr();
      for (int i = 0; i < 400; i++) begin
         if (!st) cur = rand_instr();
         drive(cur, ($urandom_range(0, 7) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
               {$urandom, $urandom}, ($urandom_range(0, 59) == 0), st);
      end

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d expected records left unchecked, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_pipeline.md
# id_ex_pipeline

ID/EX pipeline register for the 5-stage RV64 core, with load-use hazard detection, bubble insertion, branch flush and write-back-to-decode bypass. It sits between decode and the execute stage. It captures decoded operands and control every cycle and presents them to execute, ALU control and the forwarding unit. It stalls PC and IF/ID for exactly one cycle on a load-use hazard.

## Interface
Parameters:
- XLEN, 64, datapath width
- CNT_W, 32, width of the stall/flush performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- ID_PC, ID_readData1, ID_readData2, ID_imm  in  XLEN  decoded PC, register-file reads, sign-extended immediate
- ID_rs1, ID_rs2, ID_rd  in  5  register addresses
- ID_funct3 / ID_funct7  in  3 / 7  function fields
- ID_ALUOp  in  2  ALU operation class
- ID_ALUSrc, ID_Branch, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite  in  1 each  decode controls
- ID_valid  in  1  IF/ID holds a real instruction
- flush  in  1  taken branch resolved in MEM; squash ID and EX contents
- WB_RegWrite  in  1, WB_rd  in  5, WB_data  in  XLEN  write-back port, used for the decode bypass
- EX_* (PC, readData1, readData2, imm, rs1, rs2, rd, funct3, funct7, ALUOp, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, valid)  out  same widths  registered ID/EX contents
- PCWrite  out  1  0 = hold PC
- IF_ID_Write  out  1  0 = hold IF/ID
- stall  out  1  load-use bubble being inserted this cycle
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Hazard, combinational: hazard = EX_valid & EX_MemRead & (EX_rd != 0) & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2)) & ID_valid.
- Stall gating: stall = hazard & ~flush. PCWrite = IF_ID_Write = ~stall.
- Decode bypass: if WB_RegWrite & (WB_rd != 0) & (WB_rd == ID_rs1), captured readData1 = WB_data. The same rule applies independently to rs2/readData2.
- Capture priority at each rising edge:
  1. reset: all EX_* = 0.
  2. flush: bubble.
  3. stall: bubble.
  4. Otherwise: load all ID_* (bypassed data); EX_valid = ID_valid.
- Bubble: EX_valid, RegWrite, MemRead, MemWrite, Branch, MemtoReg, ALUSrc = 0 and ALUOp = 00. Data and address fields still load from ID; they are don't-care.
- ID_valid = 0 with no stall or flush: the register loads normally, so EX_valid = 0 and the controls pass through as decoded; the valid bit alone marks the slot empty.
- Counters:
  - stall_count increments on each cycle with stall = 1.
  - flush_count increments on each cycle with flush = 1.
  - Both saturate at all-ones and never wrap.
  - Both clear on reset.

## Timing
- Latency: one cycle, ID inputs to EX outputs.
- Combinational paths:
  - stall, PCWrite and IF_ID_Write depend combinationally on the current EX_* registers and ID_rs1/ID_rs2, with no added register stage.
  - The decode bypass is combinational on the WB_* ports within the same cycle.
- Stall duration:
  - A load-use stall lasts exactly one cycle. The following cycle EX holds a bubble, so hazard deasserts.
  - The held IF/ID instruction is captured on the next edge.
- Simultaneous flush and hazard: flush wins. stall = 0, PCWrite = 1, and a bubble is inserted.
- Reset values:
  - All EX_* = 0 and both counters = 0.
  - stall = 0 and PCWrite = IF_ID_Write = 1, since EX_valid = 0.
- Reset mid-stall: the next edge clears EX; there is no leftover stall.
- rd = x0: never a hazard and never bypassed.
- rs1 == rs2 == load rd: a single one-cycle stall.

## Structure
- Shared package pipe_pkg:
  - XLEN
  - ALUOp encodings (00 load/store, 01 branch, 10 R-type)
  - a packed id_ex_ctrl_t bundle {ALUOp, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite}
  - the constant CTRL_BUBBLE = all zeros
- Sub-module hazard_detect_unit, purely combinational:
  - Inputs: EX_valid, EX_MemRead, EX_rd, ID_rs1, ID_rs2, ID_valid, flush.
  - Outputs: stall, PCWrite, IF_ID_Write.
- The register, bypass muxes and counters live in id_ex_pipeline.

## Test plan
- Reset held 2 cycles, then released → all EX_* = 0, counters = 0, PCWrite = 1, stall = 0.
- Issue `add x5,x1,x2` (rs1=1, rs2=2, rd=5, RegWrite=1, ALUOp=10) → next cycle EX_rd = 5, EX_RegWrite = 1, EX_valid = 1, no stall.
- Issue `ld x6,0(x1)` (MemRead=1, rd=6), then `add x7,x6,x3` → in the second cycle stall = 1 and PCWrite = IF_ID_Write = 0. The next EX is a bubble (RegWrite = 0, MemRead = 0). The add is captured one cycle later and stall_count = 1.
- Same load, followed by an instruction with rs1=6 while flush = 1 → stall = 0, PCWrite = 1, EX is a bubble, flush_count = 1.
- WB_RegWrite = 1, WB_rd = 4, WB_data = 0x1234, ID_rs2 = 4, ID_readData2 = 0 → EX_readData2 = 0x1234. Repeat with WB_rd = 0 → EX_readData2 = 0.
- Load with rd=0 followed by rs1=0 → no stall. Separately, force stall_count to all-ones → it remains all-ones after a further stall.
